// File: rtl/led_pwm_io_if.sv
// CPU data-bus port of led_pwm_io: the same strobe/busy protocol that ram uses.
interface led_pwm_io_if;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wstrb;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    modport master (
        output mem_addr, mem_wdata, mem_wmask, mem_wstrb, mem_rstrb,
        input  mem_rdata, mem_rbusy, mem_wbusy
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wmask, mem_wstrb, mem_rstrb,
        output mem_rdata, mem_rbusy, mem_wbusy
    );
endinterface

// File: rtl/led_pwm_io.sv
// Board I/O peripheral: PWM-dimmed LEDs, an activity-counter display mode and a
// debounced user button with sticky press/release events, on the rv32i data bus.
module led_pwm_io #(
    parameter int CHANNELS      = 3,
    parameter int PWM_BITS      = 8,
    parameter int DEBOUNCE_BITS = 16,
    parameter int ACT_SHIFT     = 20,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    led_pwm_io_if.slave         bus,
    input  logic                act_strb,
    input  logic                btn_in,
    output logic                btn_irq,
    output logic [CHANNELS-1:0] led_out
);
    localparam logic [5:0] W_CTRL   = 6'd0;
    localparam logic [5:0] W_STATUS = 6'd1;
    localparam logic [5:0] W_ACT    = 6'd2;
    localparam logic [5:0] W_DUTY0  = 6'd4;

    localparam logic [PWM_BITS-1:0] PWM_LAST = '1;
    // Level flips on the edge that would take deb_cnt to all-ones.
    localparam logic [DEBOUNCE_BITS-1:0] DEB_LAST = DEBOUNCE_BITS'((2 ** DEBOUNCE_BITS) - 2);
    localparam logic [CHANNELS-1:0] LED_OFF = {CHANNELS{ACTIVE_LOW}};

    logic [5:0]          word;
    logic [31:0]         lane_mask;
    logic                wr_ctrl;
    logic                wr_act;
    logic                wr_w1c;
    logic [CHANNELS-1:0] wr_duty;
    logic [31:0]         rd_val;
    logic [31:0]         rdata;

    logic [1:0]          ctrl;
    logic [PWM_BITS-1:0] duty   [CHANNELS];
    logic [PWM_BITS-1:0] shadow [CHANNELS];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [31:0]         act_cnt;
    logic [CHANNELS-1:0] act_bits;
    logic [CHANNELS-1:0] lit;

    logic [1:0]               sync_q;
    logic                     sync;
    logic                     level;
    logic [DEBOUNCE_BITS-1:0] deb_cnt;
    logic                     deb_done;
    logic                     rise;
    logic                     fall;
    logic                     press_seen;
    logic                     release_seen;

    assign word      = bus.mem_addr[7:2];
    assign lane_mask = {{8{bus.mem_wmask[3]}}, {8{bus.mem_wmask[2]}},
                        {8{bus.mem_wmask[1]}}, {8{bus.mem_wmask[0]}}};
    assign wr_ctrl   = bus.mem_wstrb && (word == W_CTRL);
    assign wr_act    = bus.mem_wstrb && (word == W_ACT) && (|bus.mem_wmask);
    assign wr_w1c    = bus.mem_wstrb && (word == W_STATUS) && bus.mem_wmask[0];

    assign bus.mem_rdata = rdata;
    assign bus.mem_rbusy = 1'b0;
    assign bus.mem_wbusy = 1'b0;

    // Address low bits and upper data lanes carry no state here.
    logic unused_bits;
    assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata, lane_mask};

    // NOTE: every always_comb assigns its outputs a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_duty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_duty[i] = bus.mem_wstrb && (word == W_DUTY0 + 6'(i));
        end
    end

    always_comb begin
        rd_val = '0;
        case (word)
            W_CTRL:   rd_val[1:0] = ctrl;
            W_STATUS: rd_val[2:0] = {release_seen, press_seen, level};
            W_ACT:    rd_val      = act_cnt;
            default:  rd_val      = '0;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            if (word == W_DUTY0 + 6'(i)) rd_val[PWM_BITS-1:0] = duty[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values; this is what makes a same-cycle read return the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            ctrl  <= '0;
            // NOTE: duty is a handful of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < CHANNELS; i++) duty[i] <= '0;
        end else begin
            if (bus.mem_rstrb) rdata <= rd_val;
            if (wr_ctrl) begin
                ctrl <= (ctrl & ~lane_mask[1:0]) | (bus.mem_wdata[1:0] & lane_mask[1:0]);
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_duty[i]) begin
                    duty[i] <= (duty[i] & ~lane_mask[PWM_BITS-1:0])
                             | (bus.mem_wdata[PWM_BITS-1:0] & lane_mask[PWM_BITS-1:0]);
                end
            end
        end
    end

    // Shadow duties reload only at the period boundary, so a period is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == PWM_LAST) begin
                for (int i = 0; i < CHANNELS; i++) shadow[i] <= duty[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cnt <= '0;
        end else if (wr_act) begin
            act_cnt <= '0;
        end else if (act_strb) begin
            act_cnt <= act_cnt + 32'd1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_act
        if (ACT_SHIFT + i < 32) begin : g_bit
            assign act_bits[i] = act_cnt[ACT_SHIFT+i];
        end else begin : g_none
            assign act_bits[i] = 1'b0;
        end
    end

    always_comb begin
        lit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lit[i] = ctrl[1] ? act_bits[i] : (ctrl[0] && (pwm_cnt < shadow[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_out <= LED_OFF;
        else        led_out <= lit ^ LED_OFF;
    end

    assign sync     = sync_q[1];
    assign deb_done = (sync != level) && (deb_cnt == DEB_LAST);
    assign rise     = deb_done && sync;
    assign fall     = deb_done && !sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            level        <= 1'b0;
            deb_cnt      <= '0;
            press_seen   <= 1'b0;
            release_seen <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_in};
            if (sync == level || deb_done) deb_cnt <= '0;
            else                           deb_cnt <= deb_cnt + 1'b1;
            if (deb_done) level <= sync;
            // A new event outranks a W1C landing on the same edge.
            press_seen   <= (press_seen   & ~(wr_w1c & bus.mem_wdata[1])) | rise;
            release_seen <= (release_seen & ~(wr_w1c & bus.mem_wdata[2])) | fall;
        end
    end

    assign btn_irq = press_seen | release_seen;
endmodule

// File: doc/led_pwm_io.md
Name: led_pwm_io

Overview:
Memory-mapped board I/O peripheral for the rv32i SoC, sitting on the CPU data bus alongside ram. It replaces hard-wired LED and button logic with N PWM-dimmed LED channels, a selectable activity-counter display mode, and a debounced user button with sticky press and release events. It uses the same strobe/busy bus protocol as ram.

Parameters:
CHANNELS, 3, number of LED outputs (1..8)
PWM_BITS, 8, PWM counter and duty width (2..16)
DEBOUNCE_BITS, 16, debounce counter width; stable period is 2^DEBOUNCE_BITS-1 cycles
ACT_SHIFT, 20, activity-counter bit shown on channel 0; channel i shows bit ACT_SHIFT+i
ACTIVE_LOW, 1, 1 means LED pins are driven low to light

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mem_addr  in  8  byte address, word aligned; bits [1:0] ignored
mem_wdata  in  32  write data
mem_wmask  in  4  byte write enables
mem_wstrb  in  1  write strobe, one cycle
mem_rstrb  in  1  read strobe, one cycle
mem_rdata  out  32  read data
mem_rbusy  out  1  tied 0
mem_wbusy  out  1  tied 0
act_strb  in  1  activity pulse, counted when high on a clk edge
btn_in  in  1  raw asynchronous button input
btn_irq  out  1  OR of the press and release sticky bits
led_out  out  CHANNELS  LED pins, polarity set by ACTIVE_LOW

Behaviour:
- Reset (async assert, sync release via clk edge) clears all state:
  - CTRL=0, DUTY=0, shadow duty=0, pwm_cnt=0, act_cnt=0, sticky bits=0, mem_rdata=0, btn_irq=0.
  - Debounced level=0; sync flops=0.
  - led_out is all LEDs off: all-ones if ACTIVE_LOW, else 0.
- Register map:
  - 0x00 CTRL rw: [0] pwm_en, [1] act_mode.
  - 0x04 STATUS: [0] btn_level ro; [1] press W1C; [2] release W1C.
  - 0x08 ACT: act_cnt ro; any write with wmask≠0 clears it.
  - 0x10+4*i DUTY[i] rw: [PWM_BITS-1:0], for i < CHANNELS.
  - Unmapped reads return 0. Unmapped writes are ignored. Unused bits read 0.
- Writes:
  - Take effect at the clk edge where mem_wstrb=1.
  - Byte lanes are gated by mem_wmask.
  - W1C bits use lane 0.
- Reads:
  - mem_rstrb samples mem_addr. mem_rdata is valid the next cycle and held until the next rstrb.
  - If rstrb and wstrb hit the same address in one cycle, the read returns the pre-write value.
- PWM:
  - pwm_cnt increments every cycle and wraps at 2^PWM_BITS-1 → 0.
  - Channel i is lit when pwm_en=1 and pwm_cnt < shadow[i].
  - shadow[i] loads DUTY[i] on the cycle pwm_cnt==all-ones, so a new duty starts at the next period boundary. There are no partial-period glitches.
  - duty=0 means never lit. Max duty means lit for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
  - pwm_en=0 forces all channels off immediately; pwm_cnt keeps running.
- Activity mode:
  - act_mode=1 overrides PWM and pwm_en. Channel i lit = act_cnt[ACT_SHIFT+i], or 0 if that bit index ≥ 32.
  - act_cnt is 32 bits, +1 per cycle with act_strb=1, and wraps at 2^32-1 → 0.
  - A write to ACT in the same cycle as act_strb leaves act_cnt=0 (the clear wins).
- led_out is registered: one cycle after the internal lit decision, then XORed with ACTIVE_LOW.
- Button:
  - btn_in passes through a 2-flop synchroniser into sync.
  - deb_cnt clears whenever sync == level. Otherwise it increments.
  - When deb_cnt reaches 2^DEBOUNCE_BITS-1 (with sync still ≠ level), level takes sync and deb_cnt clears.
  - A 0→1 level change sets press; a 1→0 change sets release.
  - If a set and a W1C of the same bit occur in one cycle, the set wins.
  - btn_irq is combinational from the sticky bits.
- Reset mid-operation: an async assert immediately forces the outputs to their reset values, including LEDs off.

Test Plan:
1. Reset, then read 0x00, 0x04, 0x08, 0x10 → all 0; led_out=3'b111 (ACTIVE_LOW=1).
2. PWM_BITS=4, CTRL=1, DUTY0=4 → led_out[0] low for exactly 4 of every 16 cycles. Write DUTY0=12 mid-period → the old duty holds until the wrap, then 12/16.
3. DUTY1=0 and DUTY2=15 → ch1 never lit; ch2 lit 15/16. Set CTRL=0 → all LEDs high within 2 cycles.
4. CTRL=2, ACT_SHIFT=0, pulse act_strb 5 times → ACT reads 5 and led_out[2:0]=~3'b101. Write ACT together with act_strb high → ACT reads 0.
5. DEBOUNCE_BITS=4, apply btn_in bounce (1 for 5 cycles, 0 for 3) then steady 1 → level rises 2+15 cycles after steady; STATUS=3'b011 and btn_irq=1.
6. Write STATUS=2 in the same cycle a release event sets → release=1 and press=0. Assert rst_n=0 mid-PWM → led_out=3'b111 asynchronously.
